// File: rtl/ara_pkg.sv
// ara_pkg: page-split constants, system AXI structs and beat-count helper.
package ara_pkg;
  localparam int unsigned PageBytes = 4096;
  localparam int unsigned MaxSplits = 5;
  localparam int unsigned AxiDataW = 512;
  localparam int unsigned AxiAddrW = 32;
  typedef enum logic {SplitIdle, SplitIssue} split_state_e;
  typedef struct packed {
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } axi_ax_t;
  typedef struct packed {
    logic [AxiDataW-1:0]   data;
    logic [AxiDataW/8-1:0] strb;
    logic                  last;
    logic                  user;
  } axi_w_t;
  typedef struct packed {
    logic [1:0] resp;
  } axi_b_t;
  typedef struct packed {
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_sys_req_t;
  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_sys_resp_t;
  function automatic logic [12:0] beats_left(input logic [11:0] addr, input logic [2:0] size);
    logic [12:0] aligned;
    aligned = {1'b0, addr & (12'hfff << size)};
    return (13'(PageBytes) - aligned) >> size;
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO; a push is accepted when full if a pop happens in the same cycle.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_WIDTH-1:0]  usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned PtrW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_WIDTH-1:0] usage_q, usage_d;
  logic push_eff, pop_eff;
  always_comb begin
    full_o   = usage_q == CNT_WIDTH'(DEPTH);
    empty_o  = usage_q == '0;
    usage_o  = usage_q;
    data_o   = mem_q[rd_q];
    pop_eff  = pop_i && !empty_o;
    push_eff = push_i && (!full_o || pop_eff);
    wr_d     = push_eff ? (wr_q == PtrW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d     = pop_eff ? (rd_q == PtrW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    usage_d  = usage_q + CNT_WIDTH'(push_eff) - CNT_WIDTH'(pop_eff);
  end
  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      usage_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      usage_q <= usage_d;
    end
  end
endmodule

// File: rtl/global_ldst_page_split_fsm.sv
// page_split_fsm: registers one upstream burst and re-issues it as page-local INCR sub-bursts.
module page_split_fsm import ara_pkg::*; #(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 en_i,
  output logic                 ready_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [7:0]           len_i,
  input  logic [2:0]           size_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [AddrWidth-1:0] mst_addr_o,
  output logic [7:0]           mst_len_o,
  output logic                 fire_o,
  output logic                 done_o,
  output logic [2:0]           splits_o
);
  split_state_e state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [8:0] rem_q, rem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [12:0] left, take;
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    left        = beats_left(addr_q[11:0], size_i);
    take        = ({4'b0, rem_q} < left) ? {4'b0, rem_q} : left;
    ready_o     = state_q == SplitIdle && en_i;
    mst_valid_o = state_q == SplitIssue;
    mst_addr_o  = addr_q;
    mst_len_o   = 8'(take - 13'd1);
    fire_o      = mst_valid_o && mst_ready_i;
    done_o      = fire_o && rem_q == take[8:0];
    splits_o    = cnt_q + 3'd1;
    if (valid_i && ready_o) begin
      state_d = SplitIssue;
      addr_d  = addr_i;
      rem_d   = {1'b0, len_i} + 9'd1;
      cnt_d   = '0;
    end
    // Every sub-burst after the first starts on the next page base.
    if (fire_o) begin
      rem_d   = rem_q - take[8:0];
      addr_d  = {addr_q[AddrWidth-1:12] + 1'b1, 12'h000};
      cnt_d   = cnt_q + 3'd1;
      state_d = done_o ? SplitIdle : SplitIssue;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SplitIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/global_ldst_page_split.sv
// global_ldst_page_split: splits system AXI bursts at 4 KiB pages and re-frames R/W/B so
// upstream sees one burst while downstream sees page-local bursts.
module global_ldst_page_split import ara_pkg::*; #(
  parameter int unsigned AxiDataWidth   = 512,
  parameter int unsigned AxiAddrWidth   = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         axi_req_t      = ara_pkg::axi_sys_req_t,
  parameter type         axi_resp_t     = ara_pkg::axi_sys_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);
  localparam logic [2:0] BeatSize = 3'($clog2(AxiDataWidth / 8));
  localparam int unsigned WlDepth = 2 * MaxOutstanding * MaxSplits;
  localparam int unsigned OsCntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned WlCntW = $clog2(WlDepth + 1);
  logic ar_ready, ar_valid, ar_fire, ar_done, aw_ready, aw_valid, aw_fire, aw_done, aw_en;
  logic [AxiAddrWidth-1:0] ar_addr, aw_addr;
  logic [7:0] ar_len, aw_len;
  logic [2:0] ar_splits, aw_splits, r_head, b_head;
  logic r_full, r_empty, r_pop, b_full, b_empty, b_pop, wl_full_unused, wl_empty, wl_pop;
  logic [OsCntW-1:0] r_usage_unused, b_usage_unused;
  logic [WlCntW-1:0] wl_usage;
  logic [8:0] wl_head, w_cnt_q, w_cnt_d;
  logic [2:0] r_cnt_q, r_cnt_d, b_cnt_q, b_cnt_d;
  logic [1:0] b_acc_q, b_acc_d, b_merged;
  logic r_hs, r_final, w_hs, w_last, b_hs, b_final, b_ready_m;
  logic unused_ok;
  assign unused_ok = ^{slv_req_i.w.last, slv_req_i.ar.size, slv_req_i.ar.burst,
                       slv_req_i.aw.size, slv_req_i.aw.burst, wl_full_unused};
  assign aw_en = !b_full && (32'(wl_usage) <= WlDepth - MaxSplits);
  page_split_fsm #(.AddrWidth(AxiAddrWidth)) i_ar_split (
    .clk_i, .rst_ni, .valid_i(slv_req_i.ar_valid), .en_i(!r_full), .ready_o(ar_ready),
    .addr_i(slv_req_i.ar.addr), .len_i(slv_req_i.ar.len), .size_i(BeatSize),
    .mst_valid_o(ar_valid), .mst_ready_i(mst_resp_i.ar_ready), .mst_addr_o(ar_addr),
    .mst_len_o(ar_len), .fire_o(ar_fire), .done_o(ar_done), .splits_o(ar_splits)
  );
  page_split_fsm #(.AddrWidth(AxiAddrWidth)) i_aw_split (
    .clk_i, .rst_ni, .valid_i(slv_req_i.aw_valid), .en_i(aw_en), .ready_o(aw_ready),
    .addr_i(slv_req_i.aw.addr), .len_i(slv_req_i.aw.len), .size_i(BeatSize),
    .mst_valid_o(aw_valid), .mst_ready_i(mst_resp_i.aw_ready), .mst_addr_o(aw_addr),
    .mst_len_o(aw_len), .fire_o(aw_fire), .done_o(aw_done), .splits_o(aw_splits)
  );
  fifo_v3 #(.DATA_WIDTH(3), .DEPTH(MaxOutstanding)) i_r_fifo (
    .clk_i, .rst_ni, .full_o(r_full), .empty_o(r_empty), .usage_o(r_usage_unused),
    .data_i(ar_splits), .push_i(ar_done), .data_o(r_head), .pop_i(r_pop)
  );
  fifo_v3 #(.DATA_WIDTH(3), .DEPTH(MaxOutstanding)) i_b_fifo (
    .clk_i, .rst_ni, .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage_unused),
    .data_i(aw_splits), .push_i(aw_done), .data_o(b_head), .pop_i(b_pop)
  );
  fifo_v3 #(.DATA_WIDTH(9), .DEPTH(WlDepth)) i_wl_fifo (
    .clk_i, .rst_ni, .full_o(wl_full_unused), .empty_o(wl_empty), .usage_o(wl_usage),
    .data_i({1'b0, aw_len} + 9'd1), .push_i(aw_fire), .data_o(wl_head), .pop_i(wl_pop)
  );
  // An empty tracking FIFO means the owning burst is still being split, so its last/B is never final.
  always_comb begin
    r_hs      = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    r_final   = !r_empty && (r_cnt_q + 3'd1 == r_head);
    r_pop     = r_hs && r_final;
    r_cnt_d   = r_hs ? (r_final ? '0 : r_cnt_q + 3'd1) : r_cnt_q;
    w_hs      = slv_req_i.w_valid && mst_resp_i.w_ready && !wl_empty;
    w_last    = w_cnt_q + 9'd1 == wl_head;
    wl_pop    = w_hs && w_last;
    w_cnt_d   = w_hs ? (w_last ? '0 : w_cnt_q + 9'd1) : w_cnt_q;
    b_final   = !b_empty && (b_cnt_q + 3'd1 == b_head);
    b_ready_m = !b_final || slv_req_i.b_ready;
    b_hs      = mst_resp_i.b_valid && b_ready_m;
    b_merged  = (mst_resp_i.b.resp > b_acc_q) ? mst_resp_i.b.resp : b_acc_q;
    b_pop     = b_hs && b_final;
    b_cnt_d   = b_hs ? (b_final ? '0 : b_cnt_q + 3'd1) : b_cnt_q;
    b_acc_d   = b_hs ? (b_final ? '0 : b_merged) : b_acc_q;
    mst_req_o             = slv_req_i;
    mst_req_o.ar.addr     = ar_addr;
    mst_req_o.ar.len      = ar_len;
    mst_req_o.ar.size     = BeatSize;
    mst_req_o.ar.burst    = 2'b01;
    mst_req_o.ar_valid    = ar_valid;
    mst_req_o.aw.addr     = aw_addr;
    mst_req_o.aw.len      = aw_len;
    mst_req_o.aw.size     = BeatSize;
    mst_req_o.aw.burst    = 2'b01;
    mst_req_o.aw_valid    = aw_valid;
    mst_req_o.w.last      = w_last;
    mst_req_o.w_valid     = slv_req_i.w_valid && !wl_empty;
    mst_req_o.b_ready     = b_ready_m;
    slv_resp_o            = mst_resp_i;
    slv_resp_o.ar_ready   = ar_ready;
    slv_resp_o.aw_ready   = aw_ready;
    slv_resp_o.r.last     = mst_resp_i.r.last && r_final;
    slv_resp_o.w_ready    = mst_resp_i.w_ready && !wl_empty;
    slv_resp_o.b_valid    = mst_resp_i.b_valid && b_final;
    slv_resp_o.b.resp     = b_merged;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_q <= '0;
      w_cnt_q <= '0;
      b_cnt_q <= '0;
      b_acc_q <= '0;
    end else begin
      r_cnt_q <= r_cnt_d;
      w_cnt_q <= w_cnt_d;
      b_cnt_q <= b_cnt_d;
      b_acc_q <= b_acc_d;
    end
  end
endmodule
